riscv_dmem_responder: RTL



---
 rtl/riscv_dmem_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
//   Responder end of the core data memory bus. Each request is captured in
//   IDLE and completed LATENCY cycles later with exactly one single-cycle
//   response pulse: ack, err, misaligned or page_fault. Storage is an
//   internal XLEN-wide word array. The first RO_BYTES bytes above BASE_ADDR
//   are read-only.
//
//   Ports
//     rstn            async active-low reset
//     clk             clock
//     dmem_req        request, held by the core until a response pulse
//     dmem_adr        byte address
//     dmem_d          store data, right-justified
//     dmem_we         1 = store, 0 = load
//     dmem_size       0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
//     dmem_q          load data, right-justified, zero-extended, ack cycle only
//     dmem_ack        successful completion pulse
//     dmem_err        bus error pulse (out of range or reserved size)
//     dmem_misaligned misaligned access pulse
//     dmem_page_fault store-to-read-only pulse
module riscv_dmem_responder #(
   parameter int                XLEN      = 64,
   parameter int                DEPTH     = 256,
   parameter logic [XLEN-1:0]   BASE_ADDR = '0,
   parameter int                RO_BYTES  = 'h100,
   parameter int                LATENCY   = 2
) (
   input  logic            rstn,
   input  logic            clk,
   input  logic            dmem_req,
   input  logic [XLEN-1:0] dmem_adr,
   input  logic [XLEN-1:0] dmem_d,
   input  logic            dmem_we,
   input  logic [2:0]      dmem_size,
   output logic [XLEN-1:0] dmem_q,
   output logic            dmem_ack,
   output logic            dmem_err,
   output logic            dmem_misaligned,
   output logic            dmem_page_fault
);

   localparam int              NB        = XLEN / 8;
   localparam int              LW        = $clog2(NB);
   localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH * NB);
   localparam logic [XLEN-1:0] RO_LIM    = XLEN'(RO_BYTES);
   localparam logic [2:0]      MAX_SIZE  = (XLEN == 64) ? 3'd3 : 3'd2;
   localparam logic [3:0]      LAT_M1    = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t state, state_n;
   logic [3:0] cnt;

   // captured transaction (data path, not reset)
   logic [XLEN-1:0] adr_c, d_c;
   logic            we_c;
   logic [2:0]      size_c;

   logic [XLEN-1:0] mem [DEPTH];

   // Byte enables for a 2^sz-byte access starting at byte lane 'lane'.
   function automatic logic [NB-1:0] byte_en(input logic [LW-1:0] lane,
                                             input logic [1:0]    sz);
      logic [NB-1:0] be;
      for (int b = 0; b < NB; b++)
         be[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << sz));
      return be;
   endfunction

   // Right-justify the addressed lanes and zero everything above 2^sz bytes.
   function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] w,
                                                input logic [LW-1:0]   lane,
                                                input logic [1:0]      sz);
      logic [XLEN-1:0] s;
      s = w >> {lane, 3'b000};
      for (int b = 0; b < NB; b++)
         if (b >= (1 << sz)) s[8*b +: 8] = 8'h00;
      return s;
   endfunction

   // In IDLE the live inputs are decoded so a LATENCY=1 response can be
   // registered on the capture edge; otherwise the captured copy is used,
   // which makes input changes after capture irrelevant.
   logic [XLEN-1:0] adr_s, offset_s;
   logic            we_s;
   logic [2:0]      size_s;
   logic [AW-1:0]   idx_s;
   logic [LW-1:0]   lane_s;

   always_comb begin
      if (state == S_IDLE) begin
         adr_s  = dmem_adr;
         we_s   = dmem_we;
         size_s = dmem_size;
      end else begin
         adr_s  = adr_c;
         we_s   = we_c;
         size_s = size_c;
      end
      offset_s = adr_s - BASE_ADDR;
      idx_s    = offset_s[LW +: AW];
      lane_s   = adr_s[LW-1:0];
   end

   logic       err_s, mis_s, pf_s, ok_s;
   logic [2:0] amask_s;

   always_comb begin
      amask_s = 3'((4'd1 << size_s[1:0]) - 4'd1);
      err_s   = (offset_s >= MEM_BYTES) || (size_s > MAX_SIZE);
      mis_s   = !err_s && (|(adr_s[2:0] & amask_s));
      pf_s    = !err_s && !mis_s && we_s && (offset_s < RO_LIM);
      ok_s    = !err_s && !mis_s && !pf_s;
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         if (state == S_IDLE && dmem_req && LATENCY > 1)
            cnt <= LAT_M1;
         else if (state == S_WAIT)
            cnt <= cnt - 4'd1;
      end
   end

   // next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (dmem_req) state_n = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT: if (cnt == 4'd1) state_n = S_RESP;
         S_RESP: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // output logic: values to register on the edge that enters RESP
   logic            resp_go;
   logic            ack_n, err_n, mis_n, pf_n;
   logic [XLEN-1:0] q_n;

   always_comb begin
      resp_go = (state_n == S_RESP) && (state != S_RESP);
      ack_n   = resp_go && ok_s;
      err_n   = resp_go && err_s;
      mis_n   = resp_go && mis_s;
      pf_n    = resp_go && pf_s;
      q_n     = '0;
      if (ack_n && !we_s)
         q_n = load_fmt(mem[idx_s], lane_s, size_s[1:0]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dmem_q          <= '0;
         dmem_ack        <= 1'b0;
         dmem_err        <= 1'b0;
         dmem_misaligned <= 1'b0;
         dmem_page_fault <= 1'b0;
      end else begin
         dmem_q          <= q_n;
         dmem_ack        <= ack_n;
         dmem_err        <= err_n;
         dmem_misaligned <= mis_n;
         dmem_page_fault <= pf_n;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && dmem_req) begin
         adr_c  <= dmem_adr;
         d_c    <= dmem_d;
         we_c   <= dmem_we;
         size_c <= dmem_size;
      end
   end

   // Store commits on the edge that ends the ack cycle. A reset during the
   // transaction clears dmem_ack, so an aborted store never lands.
   logic [NB-1:0]   be_s;
   logic [XLEN-1:0] wdata_s;

   always_comb begin
      be_s    = byte_en(lane_s, size_s[1:0]);
      wdata_s = d_c << {lane_s, 3'b000};
   end

   always_ff @(posedge clk) begin
      if (state == S_RESP && dmem_ack && we_c)
         for (int b = 0; b < NB; b++)
            if (be_s[b]) mem[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
   end

endmodule
